regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file.
- Shares that port between the core writeback path (fixed-latency, no handshake) and the long-latency unit (mul/div/load return, valid/ready) through a DEPTH-entry queue.
- Keeps a 32-bit pending scoreboard so decode can stall reads of registers still owed by the long-latency unit.
- Register-file outputs are registered on posedge; the register file samples them on the following negedge.

---
 rtl/regfile_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: merges core writeback with
// queued long-latency results and tracks registers still owed by that unit.
module regfile_wb_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     core_we,
   input  logic [4:0]               core_waddr,
   input  logic [31:0]              core_wdata,
   input  logic                     core_ovf,
   input  logic                     lu_valid,
   output logic                     lu_ready,
   input  logic [4:0]               lu_waddr,
   input  logic [31:0]              lu_wdata,
   input  logic                     issue_valid,
   input  logic [4:0]               issue_waddr,
   input  logic [4:0]               raddr1,
   input  logic [4:0]               raddr2,
   output logic                     stall,
   output logic                     core_hold,
   output logic                     rf_we,
   output logic [4:0]               rf_waddr,
   output logic [31:0]              rf_wdata,
   output logic                     rf_is_overflow,
   output logic [31:0]              pending,
   output logic                     waw_error,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [4:0]    addrMem_q [DEPTH];
   logic [31:0]   dataMem_q [DEPTH];
   logic [AW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          rfWe_q, rfWe_d;
   logic [4:0]    rfWaddr_q, rfWaddr_d;
   logic [31:0]   rfWdata_q, rfWdata_d;
   logic [31:0]   pending_q, pending_d;
   logic          waw_q, waw_d;
   logic          hold_q, hold_d;
   logic [SW-1:0] starve_q, starve_d;

   logic          coreValid, luXfer, luKeep, qEmpty;
   logic          doPop, doBypass, doPush;
   logic [4:0]    luWrAddr;

   always_comb begin
      coreValid = core_we & (core_waddr != 5'd0) & ~core_ovf;
      lu_ready  = (count_q != CW'(DEPTH));
      luXfer    = lu_valid & lu_ready;
      luKeep    = luXfer & (lu_waddr != 5'd0);
      qEmpty    = (count_q == '0);
      doPop     = ~coreValid & ~qEmpty;
      doBypass  = ~coreValid & qEmpty & luKeep;
      doPush    = luKeep & ~doBypass;
      luWrAddr  = doPop ? addrMem_q[rdPtr_q] : lu_waddr;
   end

   // Fixed priority onto the write port: core, then queue head, then bypass.
   always_comb begin
      rfWe_d    = 1'b0;
      rfWaddr_d = rfWaddr_q;
      rfWdata_d = rfWdata_q;
      if (coreValid) begin
         rfWe_d    = 1'b1;
         rfWaddr_d = core_waddr;
         rfWdata_d = core_wdata;
      end else if (doPop) begin
         rfWe_d    = 1'b1;
         rfWaddr_d = addrMem_q[rdPtr_q];
         rfWdata_d = dataMem_q[rdPtr_q];
      end else if (doBypass) begin
         rfWe_d    = 1'b1;
         rfWaddr_d = lu_waddr;
         rfWdata_d = lu_wdata;
      end
   end

   always_comb begin
      rdPtr_d = doPop  ? rdPtr_q + AW'(1) : rdPtr_q;
      wrPtr_d = doPush ? wrPtr_q + AW'(1) : wrPtr_q;
      count_d = count_q + CW'(doPush) - CW'(doPop);
   end

   // Clear is applied before set so an issue to the same register wins.
   always_comb begin
      pending_d = pending_q;
      if (doPop | doBypass) pending_d[luWrAddr] = 1'b0;
      if (issue_valid) pending_d[issue_waddr] = 1'b1;
      pending_d[0] = 1'b0;
      waw_d = waw_q | (coreValid & pending_q[core_waddr]);
   end

   // A non-empty queue that does not pop has necessarily lost to the core.
   always_comb begin
      starve_d = starve_q;
      hold_d   = 1'b0;
      if (qEmpty | doPop) begin
         starve_d = '0;
      end else if (starve_q == SW'(STARVE_MAX - 1)) begin
         starve_d = '0;
         hold_d   = 1'b1;
      end else begin
         starve_d = starve_q + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         addrMem_q[wrPtr_q] <= lu_waddr;
         dataMem_q[wrPtr_q] <= lu_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr_q   <= '0;
         wrPtr_q   <= '0;
         count_q   <= '0;
         rfWe_q    <= 1'b0;
         rfWaddr_q <= '0;
         rfWdata_q <= '0;
         pending_q <= '0;
         waw_q     <= 1'b0;
         hold_q    <= 1'b0;
         starve_q  <= '0;
      end else begin
         rdPtr_q   <= rdPtr_d;
         wrPtr_q   <= wrPtr_d;
         count_q   <= count_d;
         rfWe_q    <= rfWe_d;
         rfWaddr_q <= rfWaddr_d;
         rfWdata_q <= rfWdata_d;
         pending_q <= pending_d;
         waw_q     <= waw_d;
         hold_q    <= hold_d;
         starve_q  <= starve_d;
      end
   end

   assign rf_we          = rfWe_q;
   assign rf_waddr       = rfWaddr_q;
   assign rf_wdata       = rfWdata_q;
   assign rf_is_overflow = 1'b0;
   assign pending        = pending_q;
   assign waw_error      = waw_q;
   assign core_hold      = hold_q;
   assign fifo_count     = count_q;
   assign stall          = pending_q[raddr1] | pending_q[raddr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written corner
// sequences, and random traffic checked against a queue-based reference model.
module tb_regfile_wb_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic                   clk, rst;
   logic                   core_we, core_ovf, lu_valid, issue_valid;
   logic [4:0]             core_waddr, lu_waddr, issue_waddr, raddr1, raddr2;
   logic [31:0]            core_wdata, lu_wdata;
   logic                   lu_ready, stall, core_hold, rf_we, rf_is_overflow, waw_error;
   logic [4:0]             rf_waddr;
   logic [31:0]            rf_wdata, pending;
   logic [$clog2(DEPTH):0] fifo_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        coreWe;
      logic [4:0]  coreAddr;
      logic [31:0] coreData;
      logic        coreOvf;
      logic        luValid;
      logic [4:0]  luAddr;
      logic [31:0] luData;
      logic        issueValid;
      logic [4:0]  issueAddr;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        expWe;
      logic [4:0]  expAddr;
      logic [31:0] expData;
      logic [1:0]  expCount;
      logic        expReady;
      logic [31:0] expPend;
      logic        expStall;
      logic        expWaw;
      logic        expHold;
   } vec_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mQ[$];
   logic [31:0] mPend;
   logic        mWaw, mHold, mRfWe;
   logic [4:0]  mRfAddr;
   logic [31:0] mRfData;
   int          mStarve;

   regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata), .core_ovf(core_ovf),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
      .issue_valid(issue_valid), .issue_waddr(issue_waddr),
      .raddr1(raddr1), .raddr2(raddr2), .stall(stall), .core_hold(core_hold),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_is_overflow(rf_is_overflow),
      .pending(pending), .waw_error(waw_error), .fifo_count(fifo_count)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic cw, logic [4:0] ca, logic [31:0] cd, logic co,
                               logic lv, logic [4:0] la, logic [31:0] ld,
                               logic iv, logic [4:0] ia, logic [4:0] r1, logic [4:0] r2);
      vec_t v;
      v = '{cw, ca, cd, co, lv, la, ld, iv, ia, r1, r2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mQ.delete();
      mPend   = '0;
      mWaw    = 1'b0;
      mHold   = 1'b0;
      mRfWe   = 1'b0;
      mRfAddr = '0;
      mRfData = '0;
      mStarve = 0;
   endtask

   // Reference behaviour at one rising edge, from the inputs held across it
   task automatic modelUpdate();
      bit         cv, keep, nonEmpty, wroteLu;
      logic [4:0] luA;
      ent_t       h;
      cv       = core_we && (core_waddr != 0) && !core_ovf;
      keep     = lu_valid && (mQ.size() < DEPTH) && (lu_waddr != 0);
      nonEmpty = (mQ.size() > 0);
      wroteLu  = 0;
      luA      = '0;
      if (cv && mPend[core_waddr]) mWaw = 1'b1;
      if (cv) begin
         mRfWe = 1'b1; mRfAddr = core_waddr; mRfData = core_wdata;
         if (keep) mQ.push_back('{lu_waddr, lu_wdata});
      end else if (nonEmpty) begin
         h = mQ.pop_front();
         mRfWe = 1'b1; mRfAddr = h.a; mRfData = h.d;
         wroteLu = 1; luA = h.a;
         if (keep) mQ.push_back('{lu_waddr, lu_wdata});
      end else if (keep) begin
         mRfWe = 1'b1; mRfAddr = lu_waddr; mRfData = lu_wdata;
         wroteLu = 1; luA = lu_waddr;
      end else begin
         mRfWe = 1'b0;
      end
      mHold = 1'b0;
      if (!nonEmpty || !cv) mStarve = 0;
      else begin
         mStarve++;
         if (mStarve == STARVE_MAX) begin
            mStarve = 0;
            mHold   = 1'b1;
         end
      end
      if (wroteLu) mPend[luA] = 1'b0;
      if (issue_valid) mPend[issue_waddr] = 1'b1;
      mPend[0] = 1'b0;
   endtask

   task automatic compareModel();
      checkOutput("m_rf_we", 32'(rf_we), 32'(mRfWe));
      checkOutput("m_rf_waddr", 32'(rf_waddr), 32'(mRfAddr));
      checkOutput("m_rf_wdata", rf_wdata, mRfData);
      checkOutput("m_fifo_count", 32'(fifo_count), 32'(mQ.size()));
      checkOutput("m_lu_ready", 32'(lu_ready), 32'(mQ.size() < DEPTH));
      checkOutput("m_pending", pending, mPend);
      checkOutput("m_stall", 32'(stall), 32'(mPend[raddr1] | mPend[raddr2]));
      checkOutput("m_waw_error", 32'(waw_error), 32'(mWaw));
      checkOutput("m_core_hold", 32'(core_hold), 32'(mHold));
      checkOutput("m_rf_is_overflow", 32'(rf_is_overflow), 32'd0);
   endtask

   // Drive one cycle of inputs at the falling edge, then clock it through
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      core_we = v.coreWe; core_waddr = v.coreAddr; core_wdata = v.coreData; core_ovf = v.coreOvf;
      lu_valid = v.luValid; lu_waddr = v.luAddr; lu_wdata = v.luData;
      issue_valid = v.issueValid; issue_waddr = v.issueAddr;
      raddr1 = v.r1; raddr2 = v.r2;
      @(posedge clk);
      modelUpdate();
      #1;
      compareModel();
   endtask

   task automatic doReset();
      @(negedge clk);
      core_we = 0; core_waddr = 0; core_wdata = 0; core_ovf = 0;
      lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
      issue_valid = 0; issue_waddr = 0; raddr1 = 0; raddr2 = 0;
      rst = 1'b1;
      #1;
      modelReset();
      compareModel();
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t vecs[15];
   vec_t idle;

   initial begin
      rst = 1'b0;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      doReset();

      vecs[0]  = '{1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0,  1, 5, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0};
      vecs[1]  = '{1, 5, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0};
      vecs[2]  = '{1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 1, 9, 32'h1234, 0, 0, 0, 0,        1, 9, 32'h1234, 0, 1, 0, 0, 0, 0};
      vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0,               0, 0, 0, 0, 1, 32'h80, 1, 0, 0};
      vecs[5]  = '{1, 1, 32'h11, 0, 1, 7, 32'hAA, 0, 0, 7, 0,     1, 1, 32'h11, 1, 1, 32'h80, 1, 0, 0};
      vecs[6]  = '{1, 2, 32'h22, 0, 1, 8, 32'hBB, 0, 0, 7, 0,     1, 2, 32'h22, 2, 0, 32'h80, 1, 0, 0};
      vecs[7]  = '{1, 3, 32'h33, 0, 1, 10, 32'hCC, 0, 0, 7, 0,    1, 3, 32'h33, 2, 0, 32'h80, 1, 0, 0};
      vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0,               1, 7, 32'hAA, 1, 1, 0, 0, 0, 0};
      vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0,               1, 8, 32'hBB, 0, 1, 0, 0, 0, 0};
      vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0,               0, 0, 0, 0, 1, 32'h80, 1, 0, 0};
      vecs[11] = '{0, 0, 0, 0, 1, 7, 32'h77, 1, 7, 7, 0,          1, 7, 32'h77, 0, 1, 32'h80, 1, 0, 0};
      vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0,               0, 0, 0, 0, 1, 32'h88, 1, 0, 0};
      vecs[13] = '{1, 3, 32'h3333, 0, 0, 0, 0, 0, 0, 3, 0,        1, 3, 32'h3333, 0, 1, 32'h88, 1, 1, 0};
      vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0,               0, 0, 0, 0, 1, 32'h88, 1, 1, 0};

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].expWe));
         if (vecs[i].expWe) begin
            checkOutput($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].expData);
         end
         checkOutput($sformatf("v%0d_fifo_count", i), 32'(fifo_count), 32'(vecs[i].expCount));
         checkOutput($sformatf("v%0d_lu_ready", i), 32'(lu_ready), 32'(vecs[i].expReady));
         checkOutput($sformatf("v%0d_pending", i), pending, vecs[i].expPend);
         checkOutput($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].expStall));
         checkOutput($sformatf("v%0d_waw", i), 32'(waw_error), 32'(vecs[i].expWaw));
         checkOutput($sformatf("v%0d_hold", i), 32'(core_hold), 32'(vecs[i].expHold));
      end

      // Starvation: one queued entry loses to the core four times running
      applyStimulus(mk(1, 1, 32'h1, 0, 1, 4, 32'h44, 0, 0, 0, 0));
      checkOutput("starve_queued", 32'(fifo_count), 32'd1);
      for (int i = 1; i <= STARVE_MAX; i++) begin
         applyStimulus(mk(1, 1, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0));
         checkOutput($sformatf("starve_hold_lost%0d", i), 32'(core_hold), 32'(i == STARVE_MAX));
      end
      applyStimulus(idle);
      checkOutput("starve_pop_we", 32'(rf_we), 32'd1);
      checkOutput("starve_pop_addr", 32'(rf_waddr), 32'd4);
      checkOutput("starve_pop_data", rf_wdata, 32'h44);
      checkOutput("starve_hold_drop", 32'(core_hold), 32'd0);
      checkOutput("waw_sticky", 32'(waw_error), 32'd1);

      // Asynchronous reset with two entries queued and registers pending
      doReset();
      applyStimulus(mk(1, 1, 32'h1, 0, 1, 5, 32'h55, 1, 2, 0, 0));
      applyStimulus(mk(1, 1, 32'h1, 0, 1, 6, 32'h66, 1, 8, 0, 0));
      checkOutput("rstq_pre_count", 32'(fifo_count), 32'd2);
      checkOutput("rstq_pre_pending", pending, 32'h0000_0104);
      checkOutput("rstq_pre_ready", 32'(lu_ready), 32'd0);
      @(negedge clk);
      core_we = 0; lu_valid = 0; issue_valid = 0;
      #2 rst = 1'b1;
      #1;
      modelReset();
      checkOutput("rstq_count", 32'(fifo_count), 32'd0);
      checkOutput("rstq_pending", pending, 32'd0);
      checkOutput("rstq_rf_we", 32'(rf_we), 32'd0);
      checkOutput("rstq_ready", 32'(lu_ready), 32'd1);
      checkOutput("rstq_waw", 32'(waw_error), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(idle);
      checkOutput("rstq_post_we", 32'(rf_we), 32'd0);

      // Random traffic against the reference model, with one reset midway
      for (int i = 0; i < 400; i++) begin
         vec_t v;
         if (i == 200) doReset();
         v = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         applyStimulus(v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
